// File: rtl/fabric_pin_responder.sv
// fabric_pin_responder: SoC-side responder for the eFPGA user-design pin bus.
// Pin map: 9 = REQ (in), 8 = ACK (out), 7..0 = DATA (bidirectional).
// Four-phase handshake into a 16 x 8 mailbox shared with a host register port.
// Optional feature macro: FABRIC_PIN_SYNC_EN (2-flop synchronizers on REQ/DATA).
module fabric_pin_responder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] pad_in,
    output logic [9:0] pad_out,
    output logic [9:0] pad_oeb,
    input  logic [3:0] host_addr,
    input  logic [7:0] host_wdata,
    input  logic       host_we,
    output logic [7:0] host_rdata,
    output logic       fab_wr,
    output logic [3:0] fab_wr_addr,
    output logic       proto_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        PH2  = 2'd2,
        DAT  = 2'd3
    } state_t;

    state_t     state;
    logic       req_s;
    logic [7:0] data_s;
    logic [7:0] cmd;
    logic       ack;
    logic       drive;
    logic [7:0] rd_val;
    logic [7:0] mem [16];
    logic       fab_we;
    logic       cmd_rd;
    logic       cmd_rsv;
    logic [3:0] cmd_addr;
    logic       pad_unused;

    // ACK input pin is our own output looped back; never consumed
    assign pad_unused = pad_in[8];

`ifdef FABRIC_PIN_SYNC_EN
    logic [8:0] sync_q1;
    logic [8:0] sync_q2;

    // Two-flop synchronizer for REQ and DATA from an asynchronous fabric
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {pad_in[9], pad_in[7:0]};
            sync_q2 <= sync_q1;
        end
    end

    assign req_s  = sync_q2[8];
    assign data_s = sync_q2[7:0];
`else
    assign req_s  = pad_in[9];
    assign data_s = pad_in[7:0];
`endif

    assign cmd_rd   = cmd[7];
    assign cmd_rsv  = |cmd[6:4];
    assign cmd_addr = cmd[3:0];

    // Fabric write commits on the second REQ rise of a clean write command
    assign fab_we = (state == PH2) && req_s && !cmd_rd && !cmd_rsv;

    // Handshake FSM; all pin-facing and pulse outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd         <= '0;
            ack         <= 1'b0;
            drive       <= 1'b0;
            rd_val      <= '0;
            fab_wr      <= 1'b0;
            fab_wr_addr <= '0;
            proto_err   <= 1'b0;
        end else begin
            fab_wr    <= 1'b0;
            proto_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_s) begin
                        cmd       <= data_s;
                        ack       <= 1'b1;
                        proto_err <= |data_s[6:4];
                        state     <= CMD;
                    end
                end
                CMD: begin
                    if (!req_s) begin
                        ack    <= 1'b0;
                        drive  <= cmd_rd;
                        rd_val <= !cmd_rd ? 8'h00 : (cmd_rsv ? 8'hFF : mem[cmd_addr]);
                        state  <= PH2;
                    end
                end
                PH2: begin
                    if (req_s) begin
                        if (fab_we) begin
                            fab_wr      <= 1'b1;
                            fab_wr_addr <= cmd_addr;
                        end
                        ack   <= 1'b1;
                        state <= DAT;
                    end
                end
                DAT: begin
                    if (!req_s) begin
                        ack    <= 1'b0;
                        drive  <= 1'b0;
                        rd_val <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Mailbox storage; host write is ordered last so it wins a same-address collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: '0};
        end else begin
            if (fab_we) begin
                mem[cmd_addr] <= data_s;
            end
            if (host_we) begin
                mem[host_addr] <= host_wdata;
            end
        end
    end

    // Registered host read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rdata <= '0;
        end else begin
            host_rdata <= mem[host_addr];
        end
    end

    assign pad_out = {1'b0, ack, rd_val};
    assign pad_oeb = {1'b1, 1'b0, (drive ? 8'h00 : 8'hFF)};

endmodule

// File: tb/tb_fabric_pin_responder.sv
// Testbench for fabric_pin_responder: acts as the fabric initiator and the host.
// Expected read bytes are pushed to a scoreboard queue when a read is issued
// and popped when the DUT presents them on the pins or on host_rdata.
module tb_fabric_pin_responder;

`ifdef FABRIC_PIN_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic [9:0] pad_in;
    logic [9:0] pad_out;
    logic [9:0] pad_oeb;
    logic [3:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_we;
    logic [7:0] host_rdata;
    logic       fab_wr;
    logic [3:0] fab_wr_addr;
    logic       proto_err;

    int         n_tests;
    int         n_fail;
    int         fab_wr_cnt;
    int         perr_cnt;
    logic [7:0] model [16];
    logic [7:0] exp_q [$];

    fabric_pin_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pad_in     (pad_in),
        .pad_out    (pad_out),
        .pad_oeb    (pad_oeb),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_we    (host_we),
        .host_rdata (host_rdata),
        .fab_wr     (fab_wr),
        .fab_wr_addr(fab_wr_addr),
        .proto_err  (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitors, sampled on the inactive edge
    initial begin
        fab_wr_cnt = 0;
        perr_cnt   = 0;
        forever begin
            @(negedge clk);
            if (rst_n && fab_wr)    fab_wr_cnt++;
            if (rst_n && proto_err) perr_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic level, output int cyc);
        cyc = 0;
        while (pad_out[8] !== level && cyc < 32) begin
            tick();
            cyc++;
        end
        check_eq("ack_wait", {31'd0, pad_out[8]}, {31'd0, level});
    endtask

    task automatic sb_pop_check(input string tag, input logic [7:0] got);
        logic [7:0] e;
        check_eq({tag, "_sb_size"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq(tag, {24'd0, got}, {24'd0, e});
        end
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        host_addr  = a;
        host_wdata = d;
        host_we    = 1'b1;
        tick();
        host_we    = 1'b0;
        model[a]   = d;
    endtask

    task automatic host_read(input string tag, input logic [3:0] a);
        host_addr = a;
        exp_q.push_back(model[a]);
        tick();
        tick();
        sb_pop_check(tag, host_rdata);
    endtask

    task automatic fab_write(input logic [7:0] cmd, input logic [7:0] d,
                             input logic collide, input logic [7:0] hd);
        int c;
        pad_in[7:0] = cmd;
        repeat (3) tick();
        pad_in[9] = 1'b1;
        wait_ack(1'b1, c);
        check_eq("wr_req_ack_lat", c, LAT);
        pad_in[9] = 1'b0;
        wait_ack(1'b0, c);
        check_eq("wr_ph2_oeb", {24'd0, pad_oeb[7:0]}, 32'hFF);
        pad_in[7:0] = d;
        repeat (3) tick();
        pad_in[9] = 1'b1;
        repeat (LAT - 1) tick();
        if (collide) begin
            host_addr  = cmd[3:0];
            host_wdata = hd;
            host_we    = 1'b1;
        end
        tick();
        host_we = 1'b0;
        check_eq("wr_dat_ack", {31'd0, pad_out[8]}, 1);
        pad_in[9] = 1'b0;
        wait_ack(1'b0, c);
        pad_in[7:0] = 8'h00;
        if (collide)              model[cmd[3:0]] = hd;
        else if (cmd[6:4] == 3'd0) model[cmd[3:0]] = d;
    endtask

    task automatic fab_read(input logic [7:0] cmd, input logic stop_in_dat);
        int c;
        exp_q.push_back(cmd[6:4] != 3'd0 ? 8'hFF : model[cmd[3:0]]);
        pad_in[7:0] = cmd;
        repeat (3) tick();
        pad_in[9] = 1'b1;
        wait_ack(1'b1, c);
        check_eq("rd_req_ack_lat", c, LAT);
        pad_in[7:0] = 8'h00;
        pad_in[9]   = 1'b0;
        wait_ack(1'b0, c);
        check_eq("rd_ph2_oeb", {24'd0, pad_oeb[7:0]}, 32'h00);
        if (exp_q.size() > 0)
            check_eq("rd_ph2_data", {24'd0, pad_out[7:0]}, {24'd0, exp_q[0]});
        repeat (3) tick();
        pad_in[9] = 1'b1;
        wait_ack(1'b1, c);
        check_eq("rd_dat_oeb", {24'd0, pad_oeb[7:0]}, 32'h00);
        sb_pop_check("rd_dat_data", pad_out[7:0]);
        if (!stop_in_dat) begin
            pad_in[9] = 1'b0;
            wait_ack(1'b0, c);
            check_eq("rd_idle_oeb", {24'd0, pad_oeb[7:0]}, 32'hFF);
            check_eq("rd_idle_out", {24'd0, pad_out[7:0]}, 32'h00);
        end
    endtask

    initial begin
        int c;
        int w0;
        int p0;
        logic [3:0] a;
        logic [7:0] d;
        n_tests    = 0;
        n_fail     = 0;
        host_addr  = '0;
        host_wdata = '0;
        host_we    = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        // Reset with REQ held high
        rst_n  = 1'b0;
        pad_in = {1'b1, 1'b0, 8'h01};
        repeat (3) tick();
        check_eq("rst_ack", {31'd0, pad_out[8]}, 0);
        check_eq("rst_oeb", {22'd0, pad_oeb}, 32'h2FF);
        check_eq("rst_out", {22'd0, pad_out}, 32'h000);
        check_eq("rst_rdata", {24'd0, host_rdata}, 32'h00);
        check_eq("rst_fab_wr_addr", {28'd0, fab_wr_addr}, 0);
        rst_n = 1'b1;
        wait_ack(1'b1, c);
        check_eq("rst_release_lat", c, LAT);
        // finish that transaction as a write of 0x00 to address 1
        pad_in[9] = 1'b0;
        wait_ack(1'b0, c);
        pad_in[7:0] = 8'h00;
        repeat (3) tick();
        pad_in[9] = 1'b1;
        wait_ack(1'b1, c);
        pad_in[9] = 1'b0;
        wait_ack(1'b0, c);

        // Fabric write 0xA7 to address 5
        w0 = fab_wr_cnt;
        fab_write(8'h05, 8'hA7, 1'b0, 8'h00);
        tick();
        check_eq("wr_pulses", fab_wr_cnt - w0, 1);
        check_eq("wr_addr", {28'd0, fab_wr_addr}, 5);
        host_read("host_rd5", 4'd5);

        // Host write, fabric read
        host_write(4'd9, 8'h3C);
        fab_read(8'h89, 1'b0);

        // Reserved-bit read
        p0 = perr_cnt;
        fab_read(8'hF2, 1'b0);
        check_eq("rsv_rd_perr", perr_cnt - p0, 1);

        // Reserved-bit write is discarded
        w0 = fab_wr_cnt;
        p0 = perr_cnt;
        fab_write(8'h74, 8'h99, 1'b0, 8'h00);
        tick();
        check_eq("rsv_wr_pulses", fab_wr_cnt - w0, 0);
        check_eq("rsv_wr_perr", perr_cnt - p0, 1);
        host_read("host_rd4", 4'd4);

        // Same-cycle host/fabric collision on address 3
        w0 = fab_wr_cnt;
        fab_write(8'h03, 8'h22, 1'b1, 8'h11);
        tick();
        check_eq("col_pulses", fab_wr_cnt - w0, 1);
        host_read("host_rd3", 4'd3);
        fab_read(8'h83, 1'b0);

        // Assorted write/read-back patterns
        for (int i = 0; i < 4; i++) begin
            a = 4'($urandom_range(0, 15));
            d = 8'($urandom);
            fab_write({4'h0, a}, d, 1'b0, 8'h00);
            fab_read({4'h8, a}, 1'b0);
            host_read("host_rd_rand", a);
        end

        // Reset in the DAT phase of a read
        fab_read(8'h89, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_ack", {31'd0, pad_out[8]}, 0);
        check_eq("midrst_oeb", {22'd0, pad_oeb}, 32'h2FF);
        check_eq("midrst_out", {22'd0, pad_out}, 32'h000);
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        pad_in = '0;
        tick();
        rst_n = 1'b1;
        tick();
        w0 = fab_wr_cnt;
        fab_write(8'h00, 8'h5A, 1'b0, 8'h00);
        tick();
        check_eq("post_rst_pulses", fab_wr_cnt - w0, 1);
        check_eq("post_rst_addr", {28'd0, fab_wr_addr}, 0);
        host_read("host_rd0", 4'd0);
        host_read("host_rd9_cleared", 4'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
